// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder: FSM encodings, default width, counter width.
package addsub_pkg;

  localparam int DEF_N = 4;

  // Bit counter only has to reach N-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_w(DEF_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add4_fa1.sv
// 1-bit full adder, one per operand pair in the serial datapath.
module fa1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add4.sv
// Bit-serial dual adder: latches two operand pairs, adds them LSB-first over
// N cycles, then presents both (N+1)-bit sums with a one-cycle DONE pulse.
// N must be at least 2.
module serial_add4
  import addsub_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [N:0]   s1,
  output logic [N:0]   s2,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_w(N);

  state_t         state, state_nx;
  logic [N-1:0]   sa, sb, sc, sd;
  logic [N-1:0]   sum1, sum2;
  logic           cy1, cy2;
  logic [CW-1:0]  cnt;
  logic           fs1, fc1, fs2, fc2;
  logic           last;

  fa1 u_fa_p1 (.a(sa[0]), .b(sb[0]), .cin(cy1), .s(fs1), .cout(fc1));
  fa1 u_fa_p2 (.a(sc[0]), .b(sd[0]), .cin(cy2), .s(fs2), .cout(fc2));

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == FIN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: START only matters in IDLE; FIN is a single cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch on accept, shift one bit per RUN cycle, load outputs on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sc   <= '0;
      sd   <= '0;
      sum1 <= '0;
      sum2 <= '0;
      cy1  <= 1'b0;
      cy2  <= 1'b0;
      cnt  <= '0;
      s1   <= '0;
      s2   <= '0;
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      sc  <= c;
      sd  <= d;
      cy1 <= 1'b0;
      cy2 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      sc   <= sc >> 1;
      sd   <= sd >> 1;
      sum1 <= {fs1, sum1[N-1:1]};
      sum2 <= {fs2, sum2[N-1:1]};
      cy1  <= fc1;
      cy2  <= fc2;
      cnt  <= cnt + CW'(1);
      // Outputs take the completed word directly so no partial sum is ever visible.
      if (last) begin
        s1 <= {fc1, fs1, sum1[N-1:1]};
        s2 <= {fc2, fs2, sum2[N-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_serial_add4.sv
// Scoreboard bench for serial_add4: stimulus pushes expected sums, a monitor
// pops and compares on every DONE.
module tb_serial_add4;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [N:0]   s1, s2;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*N+1:0] exp_q[$];

  serial_add4 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .s1(s1), .s2(s2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && busy && done) chk("busy_done_overlap", 1, 0);
    if (rst_n && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        logic [2*N+1:0] e;
        e = exp_q.pop_front();
        chk("s1", 32'(s1), 32'(e[2*N+1:N+1]));
        chk("s2", 32'(s2), 32'(e[N:0]));
      end
    end
  end

  // One accepted operation; checks BUSY length and DONE latency.
  // Inputs are scrambled right after acceptance to prove they were latched.
  task automatic run_op(input logic [N-1:0] ia, ib, ic, id, input logic [N:0] e1, e2);
    int nb, at;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; start = 1'b1;
    exp_q.push_back({e1, e2});
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia; b = ia ^ ib; c = 4'hA; d = 4'h5;
    nb = 0; at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin at = i; break; end
    end
    chk("busy_cycles", nb, N);
    chk("done_latency", at, N + 1);
  endtask

  initial begin
    logic [N-1:0] va, vb, vc, vd;

    // Reset state
    #12;
    chk("rst_s1", 32'(s1), 0);
    chk("rst_s2", 32'(s2), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op(4'b0101, 4'b0010, 4'b0110, 4'b1100, 5'b00111, 5'b10010);
    run_op(4'b1111, 4'b1111, 4'b1111, 4'b1111, 5'b11110, 5'b11110);
    run_op(4'b0000, 4'b0000, 4'b0000, 4'b0000, 5'b00000, 5'b00000);
    run_op(4'b1000, 4'b1000, 4'b0001, 4'b1111, 5'b10000, 5'b10000);

    // START re-pulsed with new operands during RUN is ignored
    @(negedge clk);
    a = 4'b0101; b = 4'b0010; c = 4'b0110; d = 4'b1100; start = 1'b1;
    exp_q.push_back({5'b00111, 5'b10010});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b1100; b = 4'b0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // START held high: back-to-back, accepted every N+2 edges
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      va = 4'(j); vb = 4'(j * 3); vc = 4'(~j); vd = 4'(j + 7);
      a = va; b = vb; c = vc; d = vd; start = 1'b1;
      if (j % 6 == 0) exp_q.push_back({5'(va) + 5'(vb), 5'(vc) + 5'(vd)});
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the 2nd RUN cycle aborts with no DONE
    run_op(4'b0011, 4'b0100, 4'b1001, 4'b0010, 5'b00111, 5'b01011);
    @(negedge clk);
    a = 4'b1111; b = 4'b0001; c = 4'b0111; d = 4'b0111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_s1", 32'(s1), 0);
    chk("abort_s2", 32'(s2), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_op(4'b1001, 4'b0111, 4'b1110, 4'b0011, 5'b10000, 5'b10001);

    // Sweep all (a,b) pairs with derived (c,d)
    for (int i = 0; i < 256; i++) begin
      va = 4'(i >> 4); vb = 4'(i); vc = ~va; vd = vb + 4'd3;
      run_op(va, vb, vc, vd, 5'(va) + 5'(vb), 5'(vc) + 5'(vd));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
